// File: rtl/grid_cursor_pkg.sv
// rtl/grid_cursor_pkg.sv - direction type and button priority encoder for grid_cursor
package grid_cursor_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  // Highest-priority held button wins: up > down > left > right.
  function automatic dir_e prio_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    dir_e d;
    d = DIR_NONE;
    if (up)         d = DIR_UP;
    else if (down)  d = DIR_DOWN;
    else if (left)  d = DIR_LEFT;
    else if (right) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/repeat_timer.sv
// rtl/repeat_timer.sv - hold-to-repeat timer: first fire after REPEAT_DELAY, then every REPEAT_RATE
module repeat_timer #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic hold,
  output logic fire
);

  localparam int MAX_V = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W = $clog2(MAX_V + 1);
  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Countdown: reload on any direction change or release, fire when it reaches the last hold cycle.
  always_comb begin
    cnt_d = cnt_q;
    fire  = 1'b0;
    if (restart || !hold) begin
      cnt_d = DELAY_LD;
    end else if (REPEAT_DELAY != 0) begin
      if (cnt_q == CNT_W'(1)) begin
        fire  = 1'b1;
        cnt_d = RATE_LD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Counter register; reset leaves it armed with the initial delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= DELAY_LD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/grid_cursor.sv
// rtl/grid_cursor.sv - keypad grid cursor with auto-repeat navigation and select capture
module grid_cursor import grid_cursor_pkg::*; #(
  parameter  int ROWS         = 4,
  parameter  int COLS         = 7,
  parameter  int WRAP         = 0,
  parameter  int REPEAT_DELAY = 50,
  parameter  int REPEAT_RATE  = 10,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int NPOS = ROWS * COLS,
  localparam int IW   = (NPOS > 1) ? $clog2(NPOS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_sel,
  output logic [RW-1:0]   row,
  output logic [CW-1:0]   col,
  output logic [IW-1:0]   pos_idx,
  output logic [NPOS-1:0] pos_onehot,
  output logic            sel_valid,
  output logic [IW-1:0]   sel_code
);

  localparam logic [RW-1:0]   ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_MAX  = CW'(COLS - 1);
  localparam logic [NPOS-1:0] ONE_HOT0 = NPOS'(1);

  dir_e            dir_now, dir_prev_q, dir_prev_d;
  logic            dir_change, holding, new_press, rep_fire, move;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [IW-1:0]   pos_idx_q, pos_idx_d;
  logic [NPOS-1:0] pos_onehot_q, pos_onehot_d;
  logic            sel_prev_q, sel_prev_d, sel_rise;
  logic            sel_valid_q, sel_valid_d;
  logic [IW-1:0]   sel_code_q, sel_code_d;

  // Resolve the active direction and classify it as a fresh press or a continued hold.
  always_comb begin
    dir_now    = prio_dir(btn_up, btn_down, btn_left, btn_right);
    dir_prev_d = dir_now;
    dir_change = (dir_now != dir_prev_q);
    holding    = !dir_change && (dir_now != DIR_NONE);
    new_press  = dir_change && (dir_now != DIR_NONE);
    move       = new_press || rep_fire;
  end

  repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (dir_change),
    .hold    (holding),
    .fire    (rep_fire)
  );

  // Next position with saturate or wrap at the grid edges; index and one-hot follow the new row/col.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (move) begin
      case (dir_now)
        DIR_UP:    if (row_q != ROW_MAX) row_d = row_q + RW'(1);
                   else if (WRAP != 0)   row_d = '0;
        DIR_DOWN:  if (row_q != '0)      row_d = row_q - RW'(1);
                   else if (WRAP != 0)   row_d = ROW_MAX;
        DIR_RIGHT: if (col_q != COL_MAX) col_d = col_q + CW'(1);
                   else if (WRAP != 0)   col_d = '0;
        DIR_LEFT:  if (col_q != '0)      col_d = col_q - CW'(1);
                   else if (WRAP != 0)   col_d = COL_MAX;
        default: ;
      endcase
    end
    pos_idx_d    = IW'(row_d) * IW'(COLS) + IW'(col_d);
    pos_onehot_d = ONE_HOT0 << pos_idx_d;
  end

  // Select edge detect; the code captured is the index before any same-cycle move.
  always_comb begin
    sel_rise    = btn_sel && !sel_prev_q;
    sel_prev_d  = btn_sel;
    sel_valid_d = sel_rise;
    sel_code_d  = sel_rise ? pos_idx_q : sel_code_q;
  end

  // State registers; reset returns the cursor home and forgets any held direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_prev_q   <= DIR_NONE;
      row_q        <= '0;
      col_q        <= '0;
      pos_idx_q    <= '0;
      pos_onehot_q <= ONE_HOT0;
      sel_prev_q   <= 1'b0;
      sel_valid_q  <= 1'b0;
      sel_code_q   <= '0;
    end else begin
      dir_prev_q   <= dir_prev_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pos_idx_q    <= pos_idx_d;
      pos_onehot_q <= pos_onehot_d;
      sel_prev_q   <= sel_prev_d;
      sel_valid_q  <= sel_valid_d;
      sel_code_q   <= sel_code_d;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign pos_idx    = pos_idx_q;
  assign pos_onehot = pos_onehot_q;
  assign sel_valid  = sel_valid_q;
  assign sel_code   = sel_code_q;

endmodule

// File: tb/tb_grid_cursor.sv
// tb/tb_grid_cursor.sv - randomized and directed bench for grid_cursor against a behavioural model
module tb_grid_cursor;

  localparam int ROWS  = 4;
  localparam int COLS  = 7;
  localparam int DELAY = 5;
  localparam int RATE  = 2;

  logic clk = 1'b0;
  logic rst;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;

  logic [1:0]  row0, row1;
  logic [2:0]  col0, col1;
  logic [4:0]  idx0, idx1;
  logic [27:0] oh0, oh1;
  logic        sv0, sv1;
  logic [4:0]  sc0, sc1;

  grid_cursor #(.ROWS(ROWS), .COLS(COLS), .WRAP(0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) u_dut_sat (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .row(row0), .col(col0), .pos_idx(idx0),
    .pos_onehot(oh0), .sel_valid(sv0), .sel_code(sc0)
  );

  grid_cursor #(.ROWS(ROWS), .COLS(COLS), .WRAP(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) u_dut_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .row(row1), .col(col1), .pos_idx(idx1),
    .pos_onehot(oh1), .sel_valid(sv1), .sel_code(sc1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: index 0 saturates, index 1 wraps.
  int m_row [2];
  int m_col [2];
  int m_code[2];
  int m_valid;
  int m_prev_dir;
  int m_hold;
  int m_prev_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_row[k] = 0; m_col[k] = 0; m_code[k] = 0;
    end
    m_valid = 0; m_prev_dir = 0; m_hold = 0; m_prev_sel = 0;
  endtask

  task automatic model_step();
    int d;
    bit mv;
    d = btn_up ? 1 : btn_down ? 2 : btn_left ? 3 : btn_right ? 4 : 0;
    if (d != m_prev_dir) m_hold = 0;
    else                 m_hold++;
    mv = (d != 0) && ((m_hold == 0) ||
         (DELAY > 0 && m_hold >= DELAY && ((m_hold - DELAY) % RATE) == 0));
    m_valid = (btn_sel && !m_prev_sel) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (m_valid == 1) m_code[k] = m_row[k] * COLS + m_col[k];
      if (mv) begin
        case (d)
          1: if (m_row[k] < ROWS - 1) m_row[k]++; else if (k == 1) m_row[k] = 0;
          2: if (m_row[k] > 0) m_row[k]--; else if (k == 1) m_row[k] = ROWS - 1;
          3: if (m_col[k] > 0) m_col[k]--; else if (k == 1) m_col[k] = COLS - 1;
          4: if (m_col[k] < COLS - 1) m_col[k]++; else if (k == 1) m_col[k] = 0;
          default: ;
        endcase
      end
    end
    m_prev_dir = d;
    m_prev_sel = btn_sel;
  endtask

  task automatic check_all(input string tag);
    int ix0, ix1;
    ix0 = m_row[0] * COLS + m_col[0];
    ix1 = m_row[1] * COLS + m_col[1];
    check({tag, "_s_row"},   32'(row0), 32'(m_row[0]));
    check({tag, "_s_col"},   32'(col0), 32'(m_col[0]));
    check({tag, "_s_idx"},   32'(idx0), 32'(ix0));
    check({tag, "_s_oh"},    32'(oh0),  32'(1) << ix0);
    check({tag, "_s_valid"}, 32'(sv0),  32'(m_valid));
    check({tag, "_s_code"},  32'(sc0),  32'(m_code[0]));
    check({tag, "_w_row"},   32'(row1), 32'(m_row[1]));
    check({tag, "_w_col"},   32'(col1), 32'(m_col[1]));
    check({tag, "_w_idx"},   32'(idx1), 32'(ix1));
    check({tag, "_w_oh"},    32'(oh1),  32'(1) << ix1);
    check({tag, "_w_valid"}, 32'(sv1),  32'(m_valid));
    check({tag, "_w_code"},  32'(sc1),  32'(m_code[1]));
  endtask

  task automatic cycle(input logic u, input logic d, input logic l, input logic r,
                       input logic s, input string tag);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse(input int dir, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(dir == 1, dir == 2, dir == 3, dir == 4, 1'b0, tag);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic       s;
    int         len;

    do_reset();
    check("reset_onehot", 32'(oh0), 32'd1);

    // Basic navigation to (2,3)
    pulse(4, 3, "nav_r");
    pulse(1, 2, "nav_u");
    check("nav_row", 32'(row0), 32'd2);
    check("nav_col", 32'(col0), 32'd3);
    check("nav_idx", 32'(idx0), 32'd17);
    check("nav_oh",  32'(oh0),  32'd1 << 17);

    // Edges: saturate versus wrap
    pulse(4, 4, "edge_r");
    check("edge_sat_col",  32'(col0), 32'd6);
    check("edge_wrap_col", 32'(col1), 32'd0);
    pulse(2, 3, "edge_d");
    check("edge_sat_row",  32'(row0), 32'd0);
    check("edge_wrap_row", 32'(row1), 32'd3);

    // Auto-repeat timing
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rep");
    check("rep_col", 32'(col0), 32'd5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rep_rel");

    // Priority and re-press on direction change
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "prio");
    check("prio_row", 32'(row0), 32'd1);
    check("prio_col", 32'(col0), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "prio_l");
    check("prio_l_col", 32'(col0), 32'd0);
    check("prio_l_wcol", 32'(col1), 32'd6);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "prio_rel");

    // Select coinciding with a move
    do_reset();
    pulse(1, 1, "sel_u");
    pulse(4, 2, "sel_r");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "sel_mv");
    check("sel_valid", 32'(sv0),  32'd1);
    check("sel_code",  32'(sc0),  32'd9);
    check("sel_idx",   32'(idx0), 32'd10);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sel_hold");
    check("sel_hold_valid", 32'(sv0), 32'd0);
    check("sel_hold_code",  32'(sc0), 32'd9);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sel_rel");

    // Reset mid-repeat with button held across release
    do_reset();
    pulse(1, 2, "mr_u");
    pulse(4, 3, "mr_r");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mr_sel");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mr_sel0");
    check("mr_code", 32'(sc0), 32'd17);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mr_hold");
    check("mr_col_pre", 32'(col0), 32'd4);
    #3;
    do_reset();
    check("mr_rst_code", 32'(sc0), 32'd0);
    check("mr_rst_oh",   32'(oh0), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mr_rel");
    check("mr_rel_col", 32'(col0), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mr_done");

    // Randomized held-button segments with occasional resets
    s = 1'b0;
    for (int seg = 0; seg < 120; seg++) begin
      pat = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 24) == 0) do_reset();
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) s = ~s;
        cycle(pat[3], pat[2], pat[1], pat[0], s, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_cursor.md
GRID_CURSOR -- requirements
Module: grid_cursor

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows (>=1).
REQ-002 SHALL have parameter COLS, default 7, number of keypad columns (>=1).
REQ-003 SHALL have parameter WRAP, default 0: 0 = saturate at edges, 1 = wrap to opposite edge.
REQ-004 SHALL have parameter REPEAT_DELAY, default 50, cycles of hold before the first auto-repeat; 0 disables auto-repeat.
REQ-005 SHALL have parameter REPEAT_RATE, default 10, cycles between subsequent auto-repeats (>=1).
REQ-006 SHALL have local widths RW=$clog2(ROWS) and CW=$clog2(COLS), each minimum 1, and IW=$clog2(ROWS*COLS), minimum 1.
REQ-007 clk  input  1  single system clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 btn_up / btn_down / btn_left / btn_right  input  1 each  level, pre-synchronised and debounced.
REQ-010 btn_sel  input  1  level, select current key.
REQ-011 row  output  RW  current cursor row, 0 = bottom.
REQ-012 col  output  CW  current cursor column, 0 = left.
REQ-013 pos_idx  output  IW  row*COLS+col.
REQ-014 pos_onehot  output  ROWS*COLS  bit pos_idx set, all others 0.
REQ-015 sel_valid  output  1  one-cycle pulse on select.
REQ-016 sel_code  output  IW  pos_idx captured at select, held until next select.

Function
REQ-017 Each cycle, the active direction SHALL be the highest-priority held button: up > down > left > right; none if no button is held.
REQ-018 A move SHALL occur at the rising edge where the active direction differs from the previous cycle's and is not none (new press); row/col update at that edge.
REQ-019 While the active direction is unchanged and not none, the repeat counter SHALL count; a move SHALL occur after REPEAT_DELAY cycles of hold, then every REPEAT_RATE cycles.
REQ-020 A change in active direction, or release, SHALL reload the repeat counter.
REQ-021 Up SHALL increment row, down decrement row, right increment col, left decrement col.
REQ-022 With WRAP=0, a move past an edge SHALL leave the position unchanged; no move counts as a repeat error.
REQ-023 With WRAP=1: row ROWS-1 up -> 0, row 0 down -> ROWS-1, col COLS-1 right -> 0, col 0 left -> COLS-1; row does not change on column wrap.
REQ-024 sel_valid SHALL pulse for exactly one cycle after a btn_sel rising edge (sampled 1, previous sample 0); holding btn_sel SHALL not repeat.
REQ-025 On a select and a move in the same cycle, sel_code SHALL capture the pre-move pos_idx.
REQ-026 pos_idx and pos_onehot SHALL be registered and consistent with row/col in every cycle, with no extra latency.

Reset
REQ-027 On rst: row=0, col=0, pos_idx=0, pos_onehot=1, sel_valid=0, sel_code=0, previous-direction=none, prev btn_sel=0, repeat counter loaded with REPEAT_DELAY.
REQ-028 A button held across reset release SHALL count as a new press on the first active edge.
REQ-029 Reset asserted mid-hold or mid-repeat SHALL abort the repeat, with no move on the release edge other than per REQ-028.

Structure
REQ-030 Package grid_cursor_pkg SHALL hold the direction enum (DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT) and the priority-encode function.
REQ-031 Sub-module repeat_timer (parameters REPEAT_DELAY, REPEAT_RATE; inputs clk, rst, restart, hold; output fire) SHALL implement REQ-019/020.
REQ-032 Counter width SHALL be $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).

Verification (ROWS=4, COLS=7, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-033 Reset, then pulse btn_right 3 times, then btn_up 2 times -> row=2, col=3, pos_idx=17, pos_onehot bit 17 set.
REQ-034 WRAP=0 at col 6, press right; at row 0, press down -> position unchanged. WRAP=1, same presses -> col 0; row 3.
REQ-035 Hold btn_right for 12 cycles from col 0 -> moves at hold cycles 0, 5, 7, 9, 11; col=5 (WRAP=0).
REQ-036 Hold btn_up and btn_left together from (0,0) -> only row advances; release up while left held -> one immediate left move (saturates at col 0).
REQ-037 btn_sel rise at pos_idx 9 in the same cycle as a right press -> sel_valid=1 for 1 cycle, sel_code=9, pos_idx=10; holding btn_sel 20 cycles -> no further pulse.
REQ-038 Assert rst mid-repeat at (2,4) -> all outputs return to their REQ-027 values asynchronously; btn_right held through release -> col=1 on the first edge.
